big_data_2d_rx: RTL and testbench

//  Receiving end of the 2D big-data transfer. Accepts a row-major stream of

---
 rtl/big_data_2d_rx.sv | 120 ++++++++++++
 tb/tb_big_data_2d_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/big_data_2d_rx.sv
// Receiver for the 2D big-data transfer: assembles a row-major SIZE_X*SIZE_Y frame, holds it for readback until released.
// Optional checksum of the held frame is enabled by defining BIG_DATA_2D_RX_CHECKSUM_EN.
module big_data_2d_rx #(
  parameter  int SIZE_X = 100,
  parameter  int SIZE_Y = 10,
  parameter  int DATA_W = 32,
  localparam int X_W    = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
  localparam int Y_W    = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              release_i,
  input  logic [X_W-1:0]    rd_x,
  input  logic [Y_W-1:0]    rd_y,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [31:0]       frame_count,
  output logic [DATA_W-1:0] frame_sum
);

  typedef enum logic {RECV, HOLD} state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(SIZE_X - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SIZE_Y - 1);

  state_t             state, nextState;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               doneQ, errQ;
  logic               acceptWord, isFinal, goodEnd, badEnd, rdInRange;
  logic [DATA_W-1:0]  frameBuf [SIZE_X][SIZE_Y];

  assign acceptWord = in_valid && in_ready;
  assign isFinal    = (x == X_LAST) && (y == Y_LAST);
  assign goodEnd    = acceptWord && isFinal && in_last;
  // A mismatch between in_last and the final position is a framing error either way.
  assign badEnd     = acceptWord && (in_last != isFinal);
  assign rdInRange  = ({1'b0, rd_x} < (X_W + 1)'(SIZE_X)) && ({1'b0, rd_y} < (Y_W + 1)'(SIZE_Y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RECV;
    else     state <= nextState;
  end

  // NOTE: combinational processes assign a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      RECV:    if (goodEnd) nextState = HOLD;
      HOLD:    if (release_i) nextState = RECV;
      default: nextState = RECV;
    endcase
  end

  // Ready is held low while reset is asserted; it never depends on in_valid.
  always_comb begin
    in_ready = (state == RECV) && !rst;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      doneQ       <= 1'b0;
      errQ        <= 1'b0;
      frame_count <= '0;
      rd_data     <= '0;
    end else begin
      doneQ   <= goodEnd;
      errQ    <= badEnd;
      rd_data <= rdInRange ? frameBuf[rd_x][rd_y] : '0;
      if (goodEnd) frame_count <= frame_count + 32'd1;
      if (acceptWord) begin
        if (isFinal || in_last) begin
          x <= '0;
          y <= '0;
        end else if (y == Y_LAST) begin
          y <= '0;
          x <= x + X_W'(1);
        end else begin
          y <= y + Y_W'(1);
        end
      end
    end
  end

  // NOTE: the frame buffer is deliberately not reset; contents are only meaningful in HOLD.
  always_ff @(posedge clk) begin
    if (acceptWord) frameBuf[x][y] <= in_data;
  end

  assign frame_done = doneQ;
  assign frame_err  = errQ;

`ifdef BIG_DATA_2D_RX_CHECKSUM_EN
  logic [DATA_W-1:0] sumQ;

  // The first word of a frame reloads the sum; a framing error clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sumQ <= '0;
    end else if (acceptWord) begin
      if (in_last != isFinal)              sumQ <= '0;
      else if ((x == '0) && (y == '0))     sumQ <= in_data;
      else                                 sumQ <= sumQ + in_data;
    end
  end

  assign frame_sum = sumQ;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_big_data_2d_rx.sv
// Directed self-checking bench for big_data_2d_rx at the default 100x10 geometry.
module tb_big_data_2d_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        release_i = 1'b0;
  logic [6:0]  rd_x = '0;
  logic [3:0]  rd_y = '0;
  logic [31:0] rd_data;
  logic        frame_done;
  logic        frame_err;
  logic [31:0] frame_count;
  logic [31:0] frame_sum;

  int checks = 0;
  int errors = 0;

`ifdef BIG_DATA_2D_RX_CHECKSUM_EN
  localparam logic [31:0] SUM_0_999 = 32'd499500;
`else
  localparam logic [31:0] SUM_0_999 = 32'd0;
`endif

  big_data_2d_rx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .release_i(release_i), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; release_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Streams words base+k for k=0..n-1; in_last on k==lastAt. Returns #1 after the last accepting edge.
  task automatic stream(input int base, input int n, input int lastAt, input bit gaps);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 5000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 32'(base + k);
      in_last  = (k == lastAt);
      @(posedge clk);
      if (in_valid && in_ready) k++;
      #1;
      budget++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (k !== n) begin
      errors++;
      $display("FAIL stream_timeout accepted=%0d required=%0d", k, n);
    end
  endtask

  task automatic read_at(input int rx, input int ry, input logic [31:0] exp, input string name);
    rd_x = 7'(rx); rd_y = 4'(ry);
    @(posedge clk); #1;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s rd_data=%0d required=%0d", name, rd_data, exp);
    end
  endtask

  task automatic release_frame();
    release_i = 1'b1;
    @(posedge clk); #1;
    release_i = 1'b0;
  endtask

  task automatic check_full_frame(input string tag);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL %s_done_pulse got=%b required=1", tag, frame_done); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL %s_no_err got=%b required=0", tag, frame_err); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_hold got=%b required=0", tag, in_ready); end
    checks++;
    if (frame_count !== 32'd1) begin errors++; $display("FAIL %s_count got=%0d required=1", tag, frame_count); end
    checks++;
    if (frame_sum !== SUM_0_999) begin errors++; $display("FAIL %s_sum got=%0d required=%0d", tag, frame_sum, SUM_0_999); end
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_done_once got=%b required=0", tag, frame_done); end
    read_at(3, 7, 32'd37, {tag, "_rd_3_7"});
    read_at(99, 9, 32'd999, {tag, "_rd_99_9"});
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || rd_data !== '0 || frame_done !== 1'b0 || frame_err !== 1'b0 ||
        frame_count !== '0 || frame_sum !== '0) begin
      errors++;
      $display("FAIL reset_values ready=%b rd=%0d done=%b err=%b cnt=%0d sum=%0d required=0,0,0,0,0,0",
               in_ready, rd_data, frame_done, frame_err, frame_count, frame_sum);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_full_frame();
    stream(0, 1000, 999, 1'b0);
    check_full_frame("full");
  endtask

  task automatic test_hold_release();
    bit sawReady = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (20) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) sawReady = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (sawReady) begin errors++; $display("FAIL hold_ignores_valid ready_seen=1 required=0"); end
    read_at(0, 0, 32'd0, "hold_rd_0_0_unchanged");
    read_at(3, 7, 32'd37, "hold_rd_3_7_unchanged");
    release_frame();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b required=1", in_ready); end
    stream(1000, 1000, 999, 1'b0);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL second_done got=%b required=1", frame_done); end
    checks++;
    if (frame_count !== 32'd2) begin errors++; $display("FAIL second_count got=%0d required=2", frame_count); end
    read_at(0, 0, 32'd1000, "second_rd_0_0");
    read_at(99, 9, 32'd1999, "second_rd_99_9");
  endtask

  task automatic test_early_last();
    stream(0, 6, 5, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL early_last_err got=%b required=1", frame_err); end
    checks++;
    if (frame_count !== 32'd0 || frame_done !== 1'b0 || frame_sum !== 32'd0) begin
      errors++;
      $display("FAIL early_last_state cnt=%0d done=%b sum=%0d required=0,0,0", frame_count, frame_done, frame_sum);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL early_last_err_once got=%b required=0", frame_err); end
    stream(0, 1000, 999, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || frame_count !== 32'd1) begin
      errors++;
      $display("FAIL resend_done done=%b cnt=%0d required=1,1", frame_done, frame_count);
    end
    read_at(0, 0, 32'd0, "resend_rd_0_0");
    read_at(0, 6, 32'd6, "resend_rd_0_6");
  endtask

  task automatic test_missing_last();
    bit sawDone = 1'b0;
    stream(0, 1000, -1, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL missing_last_err got=%b required=1", frame_err); end
    repeat (3) begin
      if (frame_done !== 1'b0) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (sawDone) begin errors++; $display("FAIL missing_last_no_done seen=1 required=0"); end
    checks++;
    if (in_ready !== 1'b1 || frame_count !== 32'd1) begin
      errors++;
      $display("FAIL missing_last_state ready=%b cnt=%0d required=1,1", in_ready, frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    stream(0, 500, -1, 1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b0 || rd_data !== '0 || frame_done !== 1'b0 || frame_err !== 1'b0 ||
        frame_count !== '0 || frame_sum !== '0) begin
      errors++;
      $display("FAIL midreset_values ready=%b rd=%0d done=%b err=%b cnt=%0d sum=%0d required=0,0,0,0,0,0",
               in_ready, rd_data, frame_done, frame_err, frame_count, frame_sum);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_pulse done=%b err=%b required=0,0", frame_done, frame_err);
    end
    stream(0, 1000, 999, 1'b0);
    checks++;
    if (frame_count !== 32'd1) begin errors++; $display("FAIL midreset_count got=%0d required=1", frame_count); end
    read_at(5, 0, 32'd50, "midreset_rd_5_0");
  endtask

  task automatic test_gaps();
    stream(0, 1000, 999, 1'b1);
    check_full_frame("gaps");
    read_at(100, 0, 32'd0, "gaps_rd_x_oob");
    read_at(0, 10, 32'd0, "gaps_rd_y_oob");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hold_release();
    do_reset();
    test_early_last();
    release_frame();
    test_missing_last();
    test_reset_mid_frame();
    do_reset();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
